// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF launch controller: FSM states and
// the challenge LFSR constants.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        FIRE,
        SAMPLE,
        DONE
    } puf_state_t;

    localparam logic [63:0] CHAL_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] CHAL_NONZERO = 64'h1;

endpackage

// File: rtl/puf_chal_lfsr.sv
// One combinational step of the right-shifting Galois LFSR that walks the
// PUF challenge sequence.
module puf_chal_lfsr #(
    parameter int CHAL_W = 64
) (
    input  logic [CHAL_W-1:0] cur,
    output logic [CHAL_W-1:0] nxt
);
    import puf_pkg::*;

    // The MSB tap guarantees a nonzero state never steps into all-zero.
    localparam logic [CHAL_W-1:0] TAPS = CHAL_TAPS[CHAL_W-1:0];

    always_comb begin
        nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
    end

endmodule

// File: rtl/puf_launch_ctrl.sv
// Drives challenge/launch timing for an arbiter PUF and collects one
// synchronized response bit per challenge into a response word.
module puf_launch_ctrl #(
    parameter int CHAL_W      = 64,
    parameter int RESP_W      = 32,
    parameter int SETTLE_CYC  = 4,
    parameter int CAPTURE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chal_valid,
    output logic              chal_ready,
    input  logic [CHAL_W-1:0] chal_seed,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_launch,
    input  logic              puf_resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic              busy
);
    import puf_pkg::*;

    localparam int               CNT_W        = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(RESP_W - 1);
    localparam logic [7:0]       SETTLE_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       CAPTURE_LAST = 8'(CAPTURE_CYC - 1);

    puf_state_t        state, state_nxt;
    logic [7:0]        timer, timer_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [CHAL_W-1:0] chal_q, chal_nxt, lfsr_out;
    logic [RESP_W-1:0] shift_q, shift_nxt;
    logic              resp_meta, resp_sync;

    puf_chal_lfsr #(.CHAL_W(CHAL_W)) u_lfsr (
        .cur (chal_q),
        .nxt (lfsr_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            chal_q    <= '0;
            shift_q   <= '0;
            resp_meta <= 1'b0;
            resp_sync <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_cnt   <= cnt_nxt;
            chal_q    <= chal_nxt;
            shift_q   <= shift_nxt;
            resp_meta <= puf_resp;
            resp_sync <= resp_meta;
        end
    end

    // Challenge only moves on acceptance or when leaving SAMPLE, so it is
    // always stable while the launch edge is in flight.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        cnt_nxt   = bit_cnt;
        chal_nxt  = chal_q;
        shift_nxt = shift_q;
        case (state)
            IDLE: begin
                if (chal_valid) begin
                    chal_nxt  = (chal_seed == '0) ? CHAL_NONZERO[CHAL_W-1:0] : chal_seed;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    timer_nxt = '0;
                    state_nxt = FIRE;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            FIRE: begin
                if (timer == CAPTURE_LAST) begin
                    timer_nxt = '0;
                    state_nxt = SAMPLE;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            SAMPLE: begin
                shift_nxt             = shift_q >> 1;
                shift_nxt[RESP_W-1]   = resp_sync;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = bit_cnt + CNT_W'(1);
                    chal_nxt  = lfsr_out;
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign chal_ready    = (state == IDLE);
    assign busy          = (state != IDLE);
    assign puf_launch    = (state == FIRE) || (state == SAMPLE);
    assign resp_valid    = (state == DONE);
    assign resp_data     = shift_q;
    assign puf_challenge = chal_q;

endmodule

// File: tb/tb_puf_launch_ctrl.sv
// Directed self-checking bench for puf_launch_ctrl with RESP_W=8 and
// 4-cycle settle/capture windows.
module tb_puf_launch_ctrl;

    localparam int          CHAL_W = 64;
    localparam int          RESP_W = 8;
    localparam logic [63:0] TAPS   = 64'hD800_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              chal_valid = 1'b0;
    logic              chal_ready;
    logic [CHAL_W-1:0] chal_seed = '0;
    logic [CHAL_W-1:0] puf_challenge;
    logic              puf_launch;
    logic              puf_resp;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [RESP_W-1:0] resp_data;
    logic              busy;

    logic              follow_chal = 1'b0;
    logic              resp_tie = 1'b0;

    int checks = 0;
    int errors = 0;
    int launch_viol = 0;
    int zero_chal = 0;
    logic [CHAL_W-1:0] prev_chal = '0;

    assign puf_resp = follow_chal ? puf_challenge[0] : resp_tie;

    always #5 clk = ~clk;

    puf_launch_ctrl #(
        .CHAL_W      (CHAL_W),
        .RESP_W      (RESP_W),
        .SETTLE_CYC  (4),
        .CAPTURE_CYC (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chal_valid    (chal_valid),
        .chal_ready    (chal_ready),
        .chal_seed     (chal_seed),
        .puf_challenge (puf_challenge),
        .puf_launch    (puf_launch),
        .puf_resp      (puf_resp),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .busy          (busy)
    );

    // Watches the whole run for challenge movement under launch and zero challenges.
    always @(negedge clk) begin
        if (!rst && puf_launch && (puf_challenge != prev_chal)) launch_viol++;
        if (busy && (puf_challenge == '0)) zero_chal++;
        prev_chal = puf_challenge;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [RESP_W-1:0] expected_word(input logic [63:0] seed);
        logic [63:0]       c;
        logic [RESP_W-1:0] w;
        c = (seed == 64'h0) ? 64'h1 : seed;
        for (int k = 0; k < RESP_W; k++) begin
            w[k] = c[0];
            c    = (c >> 1) ^ (c[0] ? TAPS : 64'h0);
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic [63:0] seed);
        chal_seed  = seed;
        chal_valid = 1'b1;
        @(posedge clk); #1;
        chal_valid = 1'b0;
    endtask

    task automatic run_word(input logic [63:0] seed, output int lat, output int pulses,
                            output int minlen, output int maxlen, output logic [63:0] first_chal);
        int run;
        lat = -1; pulses = 0; minlen = 1000; maxlen = 0; run = 0;
        applyStimulus(seed);
        first_chal = puf_challenge;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk); #1;
            if (puf_launch) begin
                run++;
            end else if (run > 0) begin
                pulses++;
                if (run < minlen) minlen = run;
                if (run > maxlen) maxlen = run;
                run = 0;
            end
            if (resp_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic finish_word(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput(tag, {63'b0, busy}, 64'h0);
    endtask

    initial begin
        int lat, pulses, minlen, maxlen, rises, bad, stray;
        logic [63:0] first_chal;
        logic [RESP_W-1:0] held;
        logic prev_launch;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_chal_ready", {63'b0, chal_ready}, 64'h1);
        checkOutput("rst_busy",       {63'b0, busy},       64'h0);
        checkOutput("rst_launch",     {63'b0, puf_launch}, 64'h0);
        checkOutput("rst_resp_valid", {63'b0, resp_valid}, 64'h0);
        checkOutput("rst_challenge",  puf_challenge,       64'h0);
        checkOutput("rst_resp_data",  {56'b0, resp_data},  64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] scenario: puf_resp tied high, seed 1");
        resp_tie = 1'b1;
        run_word(64'h1, lat, pulses, minlen, maxlen, first_chal);
        checkOutput("tie_latency", lat, 72);
        checkOutput("tie_data", {56'b0, resp_data}, 64'hFF);
        checkOutput("tie_pulses", pulses, 8);
        checkOutput("tie_pulse_min", minlen, 5);
        checkOutput("tie_pulse_max", maxlen, 5);
        checkOutput("tie_first_chal", first_chal, 64'h1);
        finish_word("tie_idle");

        $display("[TB] scenario: response follows challenge bit 0");
        follow_chal = 1'b1;
        run_word(64'h1, lat, pulses, minlen, maxlen, first_chal);
        checkOutput("follow1_latency", lat, 72);
        checkOutput("follow1_data", {56'b0, resp_data}, {56'b0, expected_word(64'h1)});
        checkOutput("follow1_bit0", {63'b0, resp_data[0]}, 64'h1);
        finish_word("follow1_idle");

        run_word(64'hB5, lat, pulses, minlen, maxlen, first_chal);
        checkOutput("followB5_data", {56'b0, resp_data}, 64'hB5);
        finish_word("followB5_idle");

        $display("[TB] scenario: zero seed with stalled consumer");
        run_word(64'h0, lat, pulses, minlen, maxlen, first_chal);
        checkOutput("zero_first_chal", first_chal, 64'h1);
        checkOutput("zero_data", {56'b0, resp_data}, {56'b0, expected_word(64'h0)});
        held = resp_data;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            chal_valid = (i % 3 == 0);
            chal_seed  = 64'hFFFF;
            @(posedge clk); #1;
            if (!resp_valid || chal_ready || (resp_data != held)) bad++;
        end
        checkOutput("stall_stable", bad, 0);
        resp_ready = 1'b1;
        chal_valid = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chal_valid = 1'b0;
        checkOutput("release_resp_valid", {63'b0, resp_valid}, 64'h0);
        checkOutput("release_chal_ready", {63'b0, chal_ready}, 64'h1);
        @(posedge clk); #1;
        checkOutput("release_seed_ignored", {63'b0, busy}, 64'h0);

        $display("[TB] scenario: reset during FIRE of bit 3");
        follow_chal = 1'b0;
        resp_tie    = 1'b1;
        applyStimulus(64'h1);
        rises = 0;
        prev_launch = puf_launch;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (puf_launch && !prev_launch) rises++;
            prev_launch = puf_launch;
            if (rises == 4) break;
        end
        checkOutput("rst_reach_bit3", rises, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_launch", {63'b0, puf_launch}, 64'h0);
        checkOutput("midrst_busy", {63'b0, busy}, 64'h0);
        checkOutput("midrst_challenge", puf_challenge, 64'h0);
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (resp_valid) stray++;
        end
        checkOutput("midrst_no_valid", stray, 0);
        follow_chal = 1'b1;
        run_word(64'hB5, lat, pulses, minlen, maxlen, first_chal);
        checkOutput("fresh_latency", lat, 72);
        checkOutput("fresh_data", {56'b0, resp_data}, 64'hB5);
        finish_word("fresh_idle");

        checkOutput("chal_stable_under_launch", launch_viol, 0);
        checkOutput("chal_never_zero", zero_chal, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_launch_ctrl.md
PUF_LAUNCH_CTRL -- requirements
Module: puf_launch_ctrl

Interface
REQ-001 Parameter CHAL_W, default 64, width of the challenge applied to the delay chains.
REQ-002 Parameter RESP_W, default 32, number of response bits gathered per request.
REQ-003 Parameter SETTLE_CYC, default 4, launch-low cycles after each challenge update; legal range 1..255.
REQ-004 Parameter CAPTURE_CYC, default 4, launch-high cycles before sampling; legal range 3..255.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 chal_valid  in  1  a seed is offered.
REQ-008 chal_ready  out  1  the block accepts a seed.
REQ-009 chal_seed  in  CHAL_W  seed for the first challenge.
REQ-010 puf_challenge  out  CHAL_W  challenge applied to the delay-chain muxes.
REQ-011 puf_launch  out  1  race edge driven into both delay chains.
REQ-012 puf_resp  in  1  arbiter flop output; asynchronous to clk.
REQ-013 resp_valid  out  1  resp_data is complete.
REQ-014 resp_ready  in  1  the consumer accepts resp_data.
REQ-015 resp_data  out  RESP_W  collected response word.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, SETTLE, FIRE, SAMPLE and DONE.
REQ-018 chal_ready SHALL equal (state==IDLE), and a seed SHALL be accepted only on chal_valid&&chal_ready.
REQ-019 On acceptance, the block SHALL load the challenge register with chal_seed, or with CHAL_NONZERO if chal_seed is all-zero; clear the bit counter; and enter SETTLE.
REQ-020 SETTLE SHALL hold puf_launch=0 for exactly SETTLE_CYC cycles, then enter FIRE.
REQ-021 FIRE SHALL hold puf_launch=1 for exactly CAPTURE_CYC cycles, then enter SAMPLE.
REQ-022 SAMPLE SHALL last one cycle with puf_launch=1.
REQ-023 In SAMPLE, the block SHALL shift the synchronized puf_resp into the MSB of the response shift register, shifting toward the LSB, so that resp_data[0] is the first challenge's bit.
REQ-024 From SAMPLE, if the bit counter equals RESP_W-1, the block SHALL enter DONE.
REQ-025 From SAMPLE, otherwise, the block SHALL increment the counter, advance the challenge by one LFSR step, and enter SETTLE.
REQ-026 The challenge SHALL change only on seed acceptance or on the SAMPLE-to-SETTLE transition, never while puf_launch=1.
REQ-027 The LFSR SHALL be Galois, right-shifting, with tap mask CHAL_TAPS; the all-zero state is unreachable.
REQ-028 puf_resp SHALL pass through a two-flop synchronizer before use; CAPTURE_CYC>=3 guarantees that the synchronized value reflects the current race.
REQ-029 DONE SHALL hold resp_valid=1 and resp_data stable until resp_ready, then return to IDLE the next cycle with resp_valid=0.
REQ-030 chal_valid SHALL be ignored outside IDLE, including in the cycle that DONE completes.
REQ-031 Per-bit latency SHALL be SETTLE_CYC+CAPTURE_CYC+1 cycles.
REQ-032 resp_valid SHALL rise RESP_W*(SETTLE_CYC+CAPTURE_CYC+1) cycles after the acceptance cycle.

Reset
REQ-033 rst SHALL force state=IDLE, puf_launch=0, resp_valid=0, busy=0, and chal_ready=1 (combinational from IDLE); and puf_challenge, resp_data, counters, and synchronizer to 0, in the cycle after it is sampled high.
REQ-034 On reset mid-operation, the block SHALL discard any partial word and SHALL NOT emit resp_valid for it.

Structure
REQ-035 Package puf_pkg SHALL hold the state enum, CHAL_TAPS (64'hD800_0000_0000_0000), and CHAL_NONZERO (64'h1).
REQ-036 The single-step LFSR SHALL be a combinational sub-module named puf_chal_lfsr with ports cur[CHAL_W] and nxt[CHAL_W].
REQ-037 The synchronizer and FSM SHALL stay in puf_launch_ctrl.

Verification (bench: RESP_W=8, SETTLE_CYC=4, CAPTURE_CYC=4)
REQ-038 Scenario: puf_resp tied 1, seed 64'h1 -> resp_valid at cycle 72 after acceptance, resp_data=8'hFF; puf_launch shows 8 pulses, each 5 cycles high.
REQ-039 Scenario: puf_resp = puf_challenge[0] modelled through the sync delay, seed 64'h1 -> resp_data matches the reference LFSR sequence, bit 0 = 1.
REQ-040 Scenario: seed 64'h0 -> first puf_challenge=64'h1; a 64'h0 challenge never appears.
REQ-041 Scenario: resp_ready held low 20 cycles in DONE -> resp_valid and resp_data stable; chal_valid pulses ignored; IDLE one cycle after resp_ready.
REQ-042 Scenario: rst asserted during FIRE of bit 3 -> puf_launch=0 and busy=0 the next cycle; no resp_valid; the following seed yields a full fresh word.
REQ-043 Scenario: assertion over all tests -> puf_challenge never changes while puf_launch=1.
